// File: rtl/rl_ram_1r1w_arb.sv
// Two-requester front end for a 1R1W RAM with a registered (one-cycle) read port.
// The write and read channels each have an independent round-robin arbiter.
// When a read and a write hit the same address in the same cycle, the written
// bytes are forwarded into the read response, so the reader sees the new data.
module rl_ram_1r1w_arb #(
   parameter int ABITS = 10,
   parameter int DBITS = 32,
   localparam int BEBITS = (DBITS + 7) / 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [1:0]            wvalid_i,
   output logic [1:0]            wready_o,
   input  logic [2*ABITS-1:0]    waddr_i,
   input  logic [2*DBITS-1:0]    wdata_i,
   input  logic [2*BEBITS-1:0]   wbe_i,
   input  logic [1:0]            rvalid_i,
   output logic [1:0]            rready_o,
   input  logic [2*ABITS-1:0]    raddr_i,
   output logic [1:0]            rsp_valid_o,
   output logic [DBITS-1:0]      rsp_data_o,
   output logic                  ram_we_o,
   output logic [ABITS-1:0]      ram_waddr_o,
   output logic [DBITS-1:0]      ram_din_o,
   output logic [BEBITS-1:0]     ram_be_o,
   output logic [ABITS-1:0]      ram_raddr_o,
   input  logic [DBITS-1:0]      ram_dout_i
);

   logic                w_last;
   logic                r_last;
   logic [1:0]          w_grant;
   logic [1:0]          r_grant;
   logic                w_sel;
   logic                r_sel;
   logic [ABITS-1:0]    w_addr_sel;
   logic [DBITS-1:0]    w_data_sel;
   logic [BEBITS-1:0]   w_be_sel;
   logic [ABITS-1:0]    r_addr_sel;
   logic [ABITS-1:0]    raddr_q;
   logic [1:0]          rsp_valid_q;
   logic                fwd_valid_q;
   logic [DBITS-1:0]    fwd_data_q;
   logic [BEBITS-1:0]   fwd_be_q;
   logic [DBITS-1:0]    fwd_mask;
   logic                collision;

   // A lone requester wins outright; on contention the one not granted last time wins.
   function automatic logic [1:0] rr_pick(input logic [1:0] valid, input logic last);
      if (valid == 2'b11) begin
         return last ? 2'b01 : 2'b10;
      end
      return valid;
   endfunction

   // Grant decode for both channels plus selection of the winning requester's fields.
   always_comb begin
      w_grant = 2'b00;
      r_grant = 2'b00;
      if (!rst_i) begin
         w_grant = rr_pick(wvalid_i, w_last);
         r_grant = rr_pick(rvalid_i, r_last);
      end
      w_sel      = w_grant[1];
      r_sel      = r_grant[1];
      w_addr_sel = w_sel ? waddr_i[ABITS +: ABITS]   : waddr_i[0 +: ABITS];
      w_data_sel = w_sel ? wdata_i[DBITS +: DBITS]   : wdata_i[0 +: DBITS];
      w_be_sel   = w_sel ? wbe_i[BEBITS +: BEBITS]   : wbe_i[0 +: BEBITS];
      r_addr_sel = r_sel ? raddr_i[ABITS +: ABITS]   : raddr_i[0 +: ABITS];
      collision  = (|w_grant) && (|r_grant) && (w_addr_sel == r_addr_sel);
   end

   assign wready_o    = w_grant;
   assign rready_o    = r_grant;
   assign ram_we_o    = |w_grant;
   assign ram_waddr_o = w_addr_sel;
   assign ram_din_o   = w_data_sel;
   assign ram_be_o    = (|w_grant) ? w_be_sel : '0;
   assign ram_raddr_o = (|r_grant) ? r_addr_sel : raddr_q;

   // Arbiter pointers, held read address, response strobe and collision flag.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         w_last      <= 1'b1;
         r_last      <= 1'b1;
         raddr_q     <= '0;
         rsp_valid_q <= 2'b00;
         fwd_valid_q <= 1'b0;
      end else begin
         if (|w_grant) begin
            w_last <= w_grant[1];
         end
         if (|r_grant) begin
            r_last  <= r_grant[1];
            raddr_q <= r_addr_sel;
         end
         rsp_valid_q <= r_grant;
         fwd_valid_q <= collision;
      end
   end

   // Capture the colliding write's data and byte enables for next-cycle merging.
   always_ff @(posedge clk_i) begin
      if (collision) begin
         fwd_data_q <= w_data_sel;
         fwd_be_q   <= w_be_sel;
      end
   end

   // Expand byte enables to a bit mask; a partial top lane only covers the bits that exist.
   always_comb begin
      fwd_mask = '0;
      for (int b = 0; b < DBITS; b++) begin
         fwd_mask[b] = fwd_be_q[b / 8];
      end
   end

   // A read in flight is dropped by a reset that arrives before its response cycle.
   assign rsp_valid_o = rsp_valid_q & {2{~rst_i}};
   assign rsp_data_o  = fwd_valid_q ? ((fwd_data_q & fwd_mask) | (ram_dout_i & ~fwd_mask))
                                    : ram_dout_i;

endmodule

// File: tb/tb_rl_ram_1r1w_arb.sv
// Directed bench for rl_ram_1r1w_arb with a behavioural registered-read RAM attached.
module tb_rl_ram_1r1w_arb;

   localparam int ABITS  = 10;
   localparam int DBITS  = 32;
   localparam int BEBITS = 4;

   logic                 clk;
   logic                 rst;
   logic [1:0]           wvalid;
   logic [1:0]           wready;
   logic [2*ABITS-1:0]   waddr;
   logic [2*DBITS-1:0]   wdata;
   logic [2*BEBITS-1:0]  wbe;
   logic [1:0]           rvalid;
   logic [1:0]           rready;
   logic [2*ABITS-1:0]   raddr;
   logic [1:0]           rsp_valid;
   logic [DBITS-1:0]     rsp_data;
   logic                 ram_we;
   logic [ABITS-1:0]     ram_waddr;
   logic [DBITS-1:0]     ram_din;
   logic [BEBITS-1:0]    ram_be;
   logic [ABITS-1:0]     ram_raddr;
   logic [DBITS-1:0]     ram_dout;

   logic [DBITS-1:0]     mem [0:(1<<ABITS)-1];

   int n_checks;
   int n_fail;

   rl_ram_1r1w_arb #(.ABITS(ABITS), .DBITS(DBITS)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .wvalid_i    (wvalid),
      .wready_o    (wready),
      .waddr_i     (waddr),
      .wdata_i     (wdata),
      .wbe_i       (wbe),
      .rvalid_i    (rvalid),
      .rready_o    (rready),
      .raddr_i     (raddr),
      .rsp_valid_o (rsp_valid),
      .rsp_data_o  (rsp_data),
      .ram_we_o    (ram_we),
      .ram_waddr_o (ram_waddr),
      .ram_din_o   (ram_din),
      .ram_be_o    (ram_be),
      .ram_raddr_o (ram_raddr),
      .ram_dout_i  (ram_dout)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // RAM model: byte-masked write, registered read returning pre-write data.
   always @(posedge clk) begin
      if (ram_we) begin
         for (int i = 0; i < BEBITS; i++) begin
            if (ram_be[i]) begin
               mem[ram_waddr][8*i +: 8] <= ram_din[8*i +: 8];
            end
         end
      end
      ram_dout <= mem[ram_raddr];
   end

   // One counted comparison with a report on mismatch.
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      n_checks++;
      assert (observed === expected) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Drives all request inputs in one go.
   task automatic applyStimulus(input logic [1:0] wv, input logic [1:0] rv);
      wvalid = wv;
      rvalid = rv;
   endtask

   // Directed sequence; inputs change on the falling edge, outputs are checked 1 unit later.
   initial begin
      logic [1:0]        exp_g;
      logic [1:0]        prev_g;
      logic [ABITS-1:0]  exp_a;
      logic [ABITS-1:0]  prev_a;
      n_checks = 0;
      n_fail   = 0;
      prev_g   = 2'b00;
      prev_a   = '0;
      for (int i = 0; i < (1 << ABITS); i++) mem[i] <= '0;
      mem[7] <= 32'h1122_3344;
      for (int i = 20; i < 23; i++) mem[i] <= 32'h5A00_0000 | i;
      for (int i = 30; i < 33; i++) mem[i] <= 32'h5A00_0000 | i;

      rst   = 1'b1;
      waddr = '0;
      wdata = '0;
      wbe   = '0;
      raddr = {10'd2, 10'd1};
      applyStimulus(2'b11, 2'b11);
      @(negedge clk); #1;
      checkOutput("reset_wready", wready, 2'b00);
      checkOutput("reset_rready", rready, 2'b00);
      checkOutput("reset_we", ram_we, 1'b0);
      checkOutput("reset_rsp_valid", rsp_valid, 2'b00);

      @(negedge clk);
      rst   = 1'b0;
      applyStimulus(2'b11, 2'b00);
      waddr = {10'd9, 10'd3};
      wdata = {32'h0000_0009, 32'h0000_0003};
      wbe   = 8'hFF;
      for (int k = 0; k < 4; k++) begin
         #1;
         checkOutput("rr_wready", wready, (k % 2) ? 2'b10 : 2'b01);
         checkOutput("rr_waddr", ram_waddr, (k % 2) ? 10'd9 : 10'd3);
         checkOutput("rr_we", ram_we, 1'b1);
         @(negedge clk);
      end

      applyStimulus(2'b00, 2'b00);
      #1;
      checkOutput("idle_we", ram_we, 1'b0);
      checkOutput("idle_be", ram_be, 4'h0);
      checkOutput("idle_wready", wready, 2'b00);
      @(negedge clk);

      applyStimulus(2'b11, 2'b00);
      waddr = {10'd41, 10'd40};
      wbe   = {4'hF, 4'h0};
      #1;
      checkOutput("zbe_wready", wready, 2'b01);
      checkOutput("zbe_we", ram_we, 1'b1);
      checkOutput("zbe_be", ram_be, 4'h0);
      @(negedge clk); #1;
      checkOutput("zbe_next_wready", wready, 2'b10);
      checkOutput("zbe_next_be", ram_be, 4'hF);
      checkOutput("zbe_next_waddr", ram_waddr, 10'd41);
      @(negedge clk);

      applyStimulus(2'b01, 2'b00);
      waddr = {10'd0, 10'd5};
      wdata = {32'h0, 32'hAABB_CCDD};
      wbe   = 8'h0F;
      #1;
      checkOutput("wr5_wready", wready, 2'b01);
      checkOutput("wr5_din", ram_din, 32'hAABB_CCDD);
      @(negedge clk);
      applyStimulus(2'b00, 2'b10);
      raddr = {10'd5, 10'd0};
      #1;
      checkOutput("rd5_rready", rready, 2'b10);
      checkOutput("rd5_raddr", ram_raddr, 10'd5);
      @(negedge clk);
      applyStimulus(2'b00, 2'b00);
      #1;
      checkOutput("rd5_rsp_valid", rsp_valid, 2'b10);
      checkOutput("rd5_rsp_data", rsp_data, 32'hAABB_CCDD);
      checkOutput("rd5_raddr_hold", ram_raddr, 10'd5);
      @(negedge clk);

      applyStimulus(2'b01, 2'b10);
      waddr = {10'd0, 10'd7};
      wdata = {32'h0, 32'hAABB_CCDD};
      wbe   = 8'h05;
      raddr = {10'd7, 10'd0};
      #1;
      checkOutput("col_wready", wready, 2'b01);
      checkOutput("col_rready", rready, 2'b10);
      @(negedge clk);
      applyStimulus(2'b00, 2'b00);
      #1;
      checkOutput("col_rsp_valid", rsp_valid, 2'b10);
      checkOutput("col_rsp_data", rsp_data, 32'h11BB_33DD);
      @(negedge clk);

      applyStimulus(2'b01, 2'b10);
      waddr = {10'd0, 10'd8};
      wdata = {32'h0, 32'hFFFF_FFFF};
      wbe   = 8'h0F;
      raddr = {10'd7, 10'd0};
      @(negedge clk);
      applyStimulus(2'b00, 2'b00);
      #1;
      checkOutput("nocol_rsp_data", rsp_data, 32'h11BB_33DD);
      @(negedge clk);

      applyStimulus(2'b00, 2'b11);
      for (int k = 0; k < 6; k++) begin
         raddr = {10'(30 + k / 2), 10'(20 + (k + 1) / 2)};
         exp_g = (k % 2) ? 2'b10 : 2'b01;
         exp_a = (k % 2) ? 10'(30 + k / 2) : 10'(20 + k / 2);
         #1;
         checkOutput("b2b_rready", rready, exp_g);
         checkOutput("b2b_raddr", ram_raddr, exp_a);
         if (k > 0) begin
            checkOutput("b2b_rsp_valid", rsp_valid, prev_g);
            checkOutput("b2b_rsp_data", rsp_data, 32'h5A00_0000 | 32'(prev_a));
         end
         prev_g = exp_g;
         prev_a = exp_a;
         @(negedge clk);
      end
      applyStimulus(2'b00, 2'b00);
      #1;
      checkOutput("b2b_last_valid", rsp_valid, prev_g);
      checkOutput("b2b_last_data", rsp_data, 32'h5A00_0000 | 32'(prev_a));
      @(negedge clk); #1;
      checkOutput("b2b_drain", rsp_valid, 2'b00);
      @(negedge clk);

      applyStimulus(2'b00, 2'b01);
      raddr = {10'd0, 10'd20};
      #1;
      checkOutput("rst_pre_rready", rready, 2'b01);
      @(negedge clk);
      rst = 1'b1;
      applyStimulus(2'b00, 2'b00);
      #1;
      checkOutput("rst_drop_n1", rsp_valid, 2'b00);
      @(negedge clk); #1;
      checkOutput("rst_drop_n2", rsp_valid, 2'b00);
      @(negedge clk);
      rst   = 1'b0;
      applyStimulus(2'b11, 2'b11);
      waddr = {10'd51, 10'd50};
      wbe   = 8'h00;
      raddr = {10'd31, 10'd21};
      #1;
      checkOutput("post_rst_rsp_valid", rsp_valid, 2'b00);
      checkOutput("post_rst_wready", wready, 2'b01);
      checkOutput("post_rst_rready", rready, 2'b01);
      @(negedge clk);
      applyStimulus(2'b00, 2'b00);
      #1;
      checkOutput("post_rst_rsp", rsp_valid, 2'b01);
      checkOutput("post_rst_data", rsp_data, 32'h5A00_0015);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rl_ram_1r1w_arb.md
RL_RAM_1R1W_ARB -- requirements
Module: rl_ram_1r1w_arb

Interface
REQ-001 Parameter: ABITS, default 10, number of RAM address bits.
REQ-002 Parameter: DBITS, default 32, number of RAM data bits; BEBITS = (DBITS+7)/8 byte enables derived locally.
REQ-003 clk_i  input  1  single clock, rising edge.
REQ-004 rst_i  input  1  synchronous, active-high reset.
REQ-005 wvalid_i  input  2  write request per requester r (bit r).
REQ-006 wready_o  output  2  write grant per requester, same cycle as accept.
REQ-007 waddr_i  input  2*ABITS  write address; requester r at [r*ABITS +: ABITS].
REQ-008 wdata_i  input  2*DBITS  write data, packed as waddr_i.
REQ-009 wbe_i  input  2*BEBITS  write byte enables, packed as waddr_i.
REQ-010 rvalid_i  input  2  read request per requester.
REQ-011 rready_o  output  2  read grant per requester.
REQ-012 raddr_i  input  2*ABITS  read address, packed as waddr_i.
REQ-013 rsp_valid_o  output  2  one-hot read response strobe.
REQ-014 rsp_data_o  output  DBITS  read response data, shared by both requesters.
REQ-015 ram_we_o  output  1  RAM write enable.
REQ-016 ram_waddr_o  output  ABITS  RAM write address.
REQ-017 ram_din_o  output  DBITS  RAM write data.
REQ-018 ram_be_o  output  BEBITS  RAM byte enables.
REQ-019 ram_raddr_o  output  ABITS  RAM read address.
REQ-020 ram_dout_i  input  DBITS  RAM read data, valid one cycle after ram_raddr_o (unregistered-output RAM).

Function
REQ-021 Write and read channels SHALL be arbitrated independently; both may be granted in the same cycle.
REQ-022 Each channel SHALL grant at most one requester per cycle; wready_o/rready_o are combinational from the valids and arbiter state, at most one bit set.
REQ-023 A requester holding valid alone SHALL be granted immediately; zero wait cycles.
REQ-024 Both valid: the channel SHALL grant the requester not granted most recently on that channel (round-robin); last-grant pointer updates only on a grant.
REQ-025 Write grant r: ram_we_o=1 and ram_waddr_o/ram_din_o/ram_be_o = requester r fields, same cycle; no write grant: ram_we_o=0, ram_be_o=0.
REQ-026 Read grant r: ram_raddr_o = raddr of r in that cycle; no grant: ram_raddr_o holds the last granted address.
REQ-027 Read latency SHALL be exactly 1 cycle: rsp_valid_o[r]=1 for one cycle in the cycle after grant, with rsp_data_o valid; no response backpressure.
REQ-028 Back-to-back reads (any requester mix) SHALL sustain one response per cycle.
REQ-029 Collision: read and write granted same cycle with equal addresses SHALL register write data and byte enables; next cycle, rsp_data_o byte i = forwarded write byte if its BE was set, else ram_dout_i byte i (new-data semantics).
REQ-030 No collision: rsp_data_o = ram_dout_i when rsp_valid_o is nonzero; rsp_data_o is don't-care but SHALL not be X-propagated from internal state when rsp_valid_o=0 (drive ram_dout_i).
REQ-031 If DBITS is not a multiple of 8, the top byte lane SHALL cover only the remaining bits in the merge.
REQ-032 Write with all byte enables zero SHALL still be granted and consume the arbitration slot.
REQ-033 Requesters SHALL hold valid and fields stable until granted; the block SHALL not store ungranted requests.

Reset
REQ-034 While rst_i=1 at a clock edge: rsp_valid_o <= 0, forwarding-valid flag <= 0, both last-grant pointers <= requester 1 (so requester 0 wins the first contention).
REQ-035 While rst_i=1, wready_o, rready_o and ram_we_o SHALL be forced to 0.
REQ-036 A read granted in the cycle before reset asserts SHALL produce no response after reset.

Verification
REQ-037 Reset, then wvalid_i=2'b11 for 4 cycles -> wready_o sequence 01,10,01,10; ram_waddr_o follows the granted requester.
REQ-038 Requester 0 writes 0xAABBCCDD to addr 5, BE=4'hF; next cycle requester 1 reads addr 5 -> rsp_valid_o=2'b10 one cycle later, rsp_data_o=0xAABBCCDD.
REQ-039 Addr 7 holds 0x11223344; same cycle: requester 0 writes 0xAABBCCDD BE=4'b0101 to addr 7, requester 1 reads addr 7 -> next cycle rsp_data_o=0x11BB33DD.
REQ-040 rvalid_i=2'b11 held 6 cycles with distinct addresses -> 6 consecutive responses alternating 01/10, each matching preloaded data.
REQ-041 Read granted in cycle N, rst_i=1 in cycle N+1 -> rsp_valid_o=0 in N+1 and after; first post-reset contention grants requester 0.
